data_memory_ctrl: RTL and testbench

- Parametrised, synchronous successor to the combinational data memory used by the non-pipelined MIPS core.
- Byte-addressed, word-organised RAM with a valid/ready request channel and a registered response channel.
- Supports per-byte write strobes and a configurable read latency.
- Sits between the core's load/store stage and storage; exactly one transaction outstanding at a time.

---
 rtl/data_memory_ctrl_if.sv | 69 ++++++
 rtl/data_memory_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl_if
//
// Groups the request and response signals between the load/store stage and
// the data memory controller.
//
// Parameters:
//   DATA_WIDTH  word width in bits (multiple of 8)
//   ADDR_WIDTH  byte address width
//
// Signals:
//   req_valid  request present                  (master -> slave)
//   req_ready  controller can accept a request  (slave  -> master)
//   req_write  1 = store, 0 = load              (master -> slave)
//   req_addr   byte address                     (master -> slave)
//   req_wdata  store data                       (master -> slave)
//   req_wstrb  byte write enables               (master -> slave)
//   rsp_valid  one-cycle response pulse         (slave  -> master)
//   rsp_rdata  load data, 0 otherwise           (slave  -> master)
//   rsp_err    misaligned / out-of-range access (slave  -> master)
//   busy       transaction in flight            (slave  -> master)
//
// Modports:
//   master  requester side (core load/store stage)
//   slave   controller side (data_memory_ctrl)
// -----------------------------------------------------------------------------
interface data_memory_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) ();

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;
  logic                    busy;

  modport master (
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output req_wstrb,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  req_wstrb,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err,
    output busy
  );

endinterface : data_memory_ctrl_if

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
//
// Synchronous, byte-addressed, word-organised data RAM for the MIPS core's
// load/store stage. A valid/ready request channel feeds a three-state FSM
// (IDLE -> [WAIT] -> RESP) that produces a registered one-cycle response
// LATENCY cycles after the accept cycle. Only one transaction is ever in
// flight; req_ready is low from the accept edge until the FSM returns to IDLE,
// so back-to-back accepts are LATENCY+1 cycles apart.
//
// Stores commit on the acceptance edge for each byte whose strobe is set.
// Loads sample the addressed word on the acceptance edge into a holding
// register that is presented on rsp_rdata only while the response is valid.
//
// Parameters:
//   DATA_WIDTH  word width in bits; multiple of 8, minimum 8   (default 32)
//   DEPTH       number of words                                (default 512)
//   ADDR_WIDTH  byte address width                             (default 32)
//   LATENCY     accept cycle to rsp_valid, legal range 1..8    (default 1)
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (memory contents are kept)
//   bus    data_memory_ctrl_if.slave - request/response channel and busy
//
// Build option:
//   DMEM_RANGE_CHECK_EN  when defined, misaligned addresses and word indices
//                        >= DEPTH respond with rsp_err=1 and never modify
//                        memory. When undefined, rsp_err is tied to 0, the low
//                        address bits are ignored and the word index wraps on
//                        its low clog2(DEPTH) bits (DEPTH should then be a
//                        power of two so every wrapped index exists).
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 1
) (
  input  logic              clk,
  input  logic              reset,
  data_memory_ctrl_if.slave bus
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int OFFSET_W = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for LATENCY-1 up to 7 with headroom.
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] hold_rdata;
  logic                  hold_err;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] word_full;
  logic [IDX_W-1:0]      idx;
  logic                  acc_err;
  logic                  accept;
  logic                  store_ok;
  logic [DATA_WIDTH-1:0] acc_rdata;

  assign word_full = bus.req_addr >> OFFSET_W;
  // Truncation to the low index bits is the wrap-around behaviour of the
  // unchecked build; in the checked build out-of-range indices are flagged
  // before they can touch memory.
  assign idx       = IDX_W'(word_full);

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(BYTES - 1);

  assign acc_err = (|(bus.req_addr & OFFSET_MASK)) ||
                   (64'(word_full) >= 64'(DEPTH));
`else
  // Low offset bits and high index bits are deliberately ignored here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.req_addr, word_full};
  assign acc_err          = 1'b0;
`endif

  assign accept    = (state == IDLE) && bus.req_valid;
  assign store_ok  = accept && bus.req_write && !acc_err;
  // Stores and errored requests always return zero data.
  assign acc_rdata = (!bus.req_write && !acc_err) ? mem[idx] : '0;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array sits in its own clocked block with no reset branch:
  // resetting it would turn it into DEPTH*DATA_WIDTH resettable flops and it
  // would also erase data that must survive a reset.
  always_ff @(posedge clk) begin
    if (store_ok) begin
      for (int i = 0; i < BYTES; i++) begin
        if (bus.req_wstrb[i]) begin
          mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every state and output register here is updated with non-blocking
  // assignments so all of them see the pre-edge values of each other; a
  // blocking assignment would let later statements observe a half-updated FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      hold_rdata    <= '0;
      hold_err      <= 1'b0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            hold_rdata    <= acc_rdata;
            hold_err      <= acc_err;
            bus.req_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (LATENCY == 1) begin
              // No wait cycles: the response is the very next cycle.
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_rdata <= acc_rdata;
              bus.rsp_err   <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= CNT_W'(1);
            end
          end
        end

        WAIT: begin
          // Counts 1 .. LATENCY-1, one WAIT cycle per count value.
          if (cnt == CNT_W'(LATENCY - 1)) begin
            state         <= RESP;
            cnt           <= '0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= hold_rdata;
            bus.rsp_err   <= hold_err;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        RESP: begin
          state         <= IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.rsp_err   <= 1'b0;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end

        default: begin
          state         <= IDLE;
          cnt           <= '0;
          bus.rsp_valid <= 1'b0;
          bus.rsp_rdata <= '0;
          bus.rsp_err   <= 1'b0;
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule : data_memory_ctrl

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
//
// Three controllers (LATENCY 1, 4 and 3) share one request driver; sel picks
// which instance sees req_valid and whose outputs are observed. A per-instance
// word array models the memory from the addressing and strobe rules, and the
// expected response timing is derived from LATENCY alone: rsp_valid in the
// LATENCY-th cycle after the accept cycle, ready again one cycle later.
// Honours DMEM_RANGE_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

  localparam int  DW     = 32;
  localparam int  AW     = 32;
  localparam int  DEPTH  = 512;
  localparam int  NDUT   = 3;
  localparam time PERIOD = 10;
  localparam int  BOUND  = 40;

`ifdef DMEM_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  int            sel;
  logic          req_valid;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_wstrb;

  logic          o_ready, o_valid, o_err, o_busy;
  logic [DW-1:0] o_rdata;

  int  checks = 0;
  int  errors = 0;
  time last_acc_t = 0;

  logic [DW-1:0] mmem [NDUT][DEPTH];

  always #(PERIOD/2) clk = ~clk;

  data_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
  data_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
  data_memory_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

  assign bus0.req_valid = req_valid && (sel == 0);
  assign bus1.req_valid = req_valid && (sel == 1);
  assign bus2.req_valid = req_valid && (sel == 2);
  assign bus0.req_write = req_write;
  assign bus1.req_write = req_write;
  assign bus2.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus1.req_addr  = req_addr;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_wdata = req_wdata;
  assign bus2.req_wdata = req_wdata;
  assign bus0.req_wstrb = req_wstrb;
  assign bus1.req_wstrb = req_wstrb;
  assign bus2.req_wstrb = req_wstrb;

  data_memory_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LATENCY(1))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  data_memory_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LATENCY(4))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  data_memory_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LATENCY(3))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  always_comb begin
    o_ready = bus0.req_ready;
    o_valid = bus0.rsp_valid;
    o_rdata = bus0.rsp_rdata;
    o_err   = bus0.rsp_err;
    o_busy  = bus0.busy;
    if (sel == 1) begin
      o_ready = bus1.req_ready;
      o_valid = bus1.rsp_valid;
      o_rdata = bus1.rsp_rdata;
      o_err   = bus1.rsp_err;
      o_busy  = bus1.busy;
    end else if (sel == 2) begin
      o_ready = bus2.req_ready;
      o_valid = bus2.rsp_valid;
      o_rdata = bus2.rsp_rdata;
      o_err   = bus2.rsp_err;
      o_busy  = bus2.busy;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference rules
  // ---------------------------------------------------------------------------
  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 3);
  endfunction

  function automatic bit m_err(input logic [AW-1:0] a);
    return RANGE_EN && (((a % 4) != 0) || ((a / 4) >= DEPTH));
  endfunction

  function automatic int m_idx(input logic [AW-1:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " req_ready"}, o_ready, 1);
    check({tag, " rsp_valid"}, o_valid, 0);
    check({tag, " rsp_rdata"}, o_rdata, 0);
    check({tag, " rsp_err"},   o_err,   0);
    check({tag, " busy"},      o_busy,  0);
  endtask

  // Apply a request at a falling edge, wait for acceptance, update the model
  // and check every cycle up to the return to idle.
  task automatic txn(input int d, input bit wr, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata, input logic [3:0] strb,
                     input bit keep, input bit check_gap);
    int            lat;
    bit            e;
    int            ix;
    int            n;
    time           acc_t;
    logic [DW-1:0] exp_rd;
    lat    = lat_of(d);
    e      = m_err(addr);
    ix     = m_idx(addr);
    exp_rd = (wr || e) ? '0 : mmem[d][ix];
    sel       = d;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = strb;
    #1;
    n = 0;
    while (o_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("d%0d accept_timeout", d), (n >= BOUND), 0);
    if (n < BOUND) begin
      @(posedge clk);
      acc_t = $time;
      if (check_gap)
        check($sformatf("d%0d accept_gap", d), (acc_t - last_acc_t) / PERIOD, lat + 1);
      last_acc_t = acc_t;
      if (wr && !e)
        for (int i = 0; i < 4; i++)
          if (strb[i]) mmem[d][ix][8*i +: 8] = wdata[8*i +: 8];
      for (int k = 1; k <= lat + 1; k++) begin
        @(negedge clk);
        check($sformatf("d%0d a%0h k%0d rsp_valid", d, addr, k), o_valid, (k == lat));
        check($sformatf("d%0d a%0h k%0d busy", d, addr, k),      o_busy,  (k <= lat));
        check($sformatf("d%0d a%0h k%0d req_ready", d, addr, k), o_ready, (k > lat));
        check($sformatf("d%0d a%0h k%0d rsp_rdata", d, addr, k), o_rdata, (k == lat) ? exp_rd : '0);
        check($sformatf("d%0d a%0h k%0d rsp_err", d, addr, k),   o_err,   (k == lat) ? e : 1'b0);
        if (k == 1 && !keep) req_valid = 1'b0;
      end
    end else begin
      req_valid = 1'b0;
    end
  endtask

  // Accept a request, assert reset one cycle later and confirm the response
  // is dropped.
  task automatic reset_in_flight(input int d, input bit wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata);
    int n;
    sel       = d;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_wstrb = 4'hF;
    #1;
    n = 0;
    while (o_ready !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("rst accept_timeout", (n >= BOUND), 0);
    @(posedge clk);
    if (wr && !m_err(addr)) mmem[d][m_idx(addr)] = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst in_flight busy", o_busy, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check_idle_outputs("rst async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= lat_of(d) + 2; k++) begin
      @(negedge clk);
      check($sformatf("rst drop k%0d rsp_valid", k), o_valid, 0);
      check($sformatf("rst drop k%0d busy", k),      o_busy,  0);
    end
  endtask

  initial begin
    #(PERIOD * 20000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    reset     = 1'b1;
    sel       = 0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;

    // Reset values.
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      sel = d;
      #1;
      check_idle_outputs($sformatf("d%0d reset", d));
    end
    reset = 1'b0;
    @(negedge clk);

    // Fill words 0..15 of every instance so later loads are defined.
    for (int d = 0; d < NDUT; d++)
      for (int w = 0; w < 16; w++)
        txn(d, 1'b1, AW'(w * 4), DW'($urandom), 4'hF, 1'b0, 1'b0);

    // Full-word store / load, then partial strobes.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0);
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0);
    check("strobe model word", mmem[0][4], 32'hDE22BE44);
    // Empty-strobe store is a no-op that still responds.
    txn(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 1'b0);

    // Misaligned load, out-of-range store, then word 0.
    txn(0, 1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h12,  32'h0,        4'h0, 1'b0, 1'b0);
    txn(0, 1'b1, 32'h800, 32'h0BADBEEF, 4'hF, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h0,   32'h0,        4'h0, 1'b0, 1'b0);

    // LATENCY=4 with req_valid held high across three requests.
    txn(1, 1'b0, 32'h20, 32'h0,        4'h0, 1'b1, 1'b0);
    txn(1, 1'b1, 32'h24, 32'h5A5AA5A5, 4'hF, 1'b1, 1'b1);
    txn(1, 1'b0, 32'h24, 32'h0,        4'h0, 1'b0, 1'b1);

    // Reset while a store and then a load are in flight (LATENCY=3).
    reset_in_flight(2, 1'b1, 32'h44, 32'h600DF00D);
    reset_in_flight(2, 1'b0, 32'h40, 32'h0);
    txn(2, 1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 1'b0);
    txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0);

    // Randomised mix over the filled words, with occasional misaligned and
    // out-of-range addresses.
    for (int d = 0; d < NDUT; d++) begin
      for (int t = 0; t < 25; t++) begin
        a = AW'($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 3) == 0) a = a + AW'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) a = a + 32'h800;
        txn(d, 1'($urandom_range(0, 1)), a, DW'($urandom), 4'($urandom_range(0, 15)),
            1'b0, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_data_memory_ctrl
